display_scan_ctrl: RTL and testbench

Time-multiplexed controller for the board's 8-digit common-anode seven-segment display. It holds a 32-bit value written by the MIPS I/O side and scans one hex digit at a time through a single shared hex-to-segment decoder. Anodes are driven one-hot with inter-digit blanking. New values are committed only at frame boundaries, so the display never tears.

---
 rtl/display_pkg.sv | 19 +
 rtl/BCD7Seg.sv | 32 +++
 rtl/display_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam int         DIGITS  = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index of the most significant non-zero nibble; 0 for a zero value so digit 0 always shows.
  function automatic logic [2:0] lead_digit(input logic [31:0] v);
    logic [2:0] msd;
    msd = '0;
    for (int k = 1; k < DIGITS; k++)
      if (v[4*k +: 4] != 4'h0) msd = 3'(k);
    return msd;
  endfunction

endpackage

// File: rtl/BCD7Seg.sv
// Hex nibble to active-low g..a segment decoder; blank forces all segments off.
module BCD7Seg (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (digit)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-digit multiplexed seven-segment scanner with frame-aligned value commit.
// Optional leading-zero suppression when DISPLAY_LZ_BLANK_EN is defined.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  output logic        wr_ready,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_tick
);

  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            frame_end;

  logic [31:0]     value, pend_value;
  logic [7:0]      dp, pend_dp;
  logic            pend_valid;
  logic            accept, commit;

  logic [3:0]      nibble;
  logic            blank;
  logic [6:0]      dec;
  logic [7:0]      seg_n, an_n;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    frame_end = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_n   = BLANK;
            cnt_n     = '0;
            idx_n     = idx + 1'b1;
            frame_end = (idx == 3'(DIGITS - 1));
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign frame_tick = frame_end;
  assign wr_ready   = ~pend_valid;
  assign accept     = wr_en & ~pend_valid;
  // Pending load only lands between frames (or while dark) so a frame never mixes values.
  assign commit     = pend_valid & (frame_end | (state == IDLE));

  assign nibble = value[{idx, 2'b00} +: 4];

`ifdef DISPLAY_LZ_BLANK_EN
  assign blank = (idx > lead_digit(value));
`else
  assign blank = 1'b0;
`endif

  BCD7Seg u_dec (
    .digit (nibble),
    .blank (blank),
    .seg   (dec)
  );

  always_comb begin
    seg_n = SEG_OFF;
    an_n  = AN_OFF;
    if (state == DRIVE) begin
      an_n[idx] = 1'b0;
      seg_n     = {~dp[idx], dec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      value      <= '0;
      dp         <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      seg   <= seg_n;
      an    <= an_n;
      if (accept) begin
        pend_value <= wr_data;
        pend_dp    <= wr_dp;
        pend_valid <= 1'b1;
      end else if (commit) begin
        value      <= pend_value;
        dp         <= pend_dp;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with DIV=4, BLANK_CYCLES=2 (48-cycle frame).
module tb_display_scan_ctrl;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst, enable, wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic        wr_ready, frame_tick;
  logic [7:0]  seg, an;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [7:0] prev_an = 8'hFF;

  display_scan_ctrl #(.DIV(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_ready   (wr_ready),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] d, input int k);
    logic [7:0] s;
    logic [3:0] nib;
    int top;
    nib = v[4*k +: 4];
    s   = HEX[nib];
    top = 0;
    for (int j = 1; j < 8; j++) if (v[4*j +: 4] != 4'h0) top = j;
`ifdef DISPLAY_LZ_BLANK_EN
    if (k > top) s = 8'hFF;
`endif
    s[7] = ~d[k];
    return s;
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic [7:0] d, input int lo, input int hi);
    exp_t e;
    for (int k = lo; k <= hi; k++) begin
      e.an  = ~(8'h01 << k);
      e.seg = exp_seg(v, d, k);
      exp_q.push_back(e);
    end
  endtask

  // Counts negedges until frame_tick, bounded well past the expected distance.
  task automatic wait_tick(input int n, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_tick && c < n + 10);
    chk(name, 16'(c), 16'(n));
  endtask

  // Monitor: every new lit window is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (an != 8'hFF && prev_an == 8'hFF) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_digit an=%h seg=%h", an, seg);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("digit", {an, seg}, {e.an, e.seg});
      end
    end
    prev_an = an;
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 8'hFF);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_frame_tick", frame_tick, 0);
    rst = 1'b0;

    // load while dark commits immediately
    wr_en = 1'b1; wr_data = 32'h1234ABCD; wr_dp = 8'h00;
    @(negedge clk); wr_en = 1'b0;
    chk("idle_accept_ready", wr_ready, 0);
    @(negedge clk);
    chk("idle_commit_ready", wr_ready, 1);

    push_frame(32'h1234ABCD, 8'h00, 0, 7);
    push_frame(32'h1234ABCD, 8'h00, 0, 7);
    push_frame(32'hFFFFFFFF, 8'h00, 0, 7);
    enable = 1'b1;
    wait_tick(48, "tick_first");

    // mid-frame load during digit 3, plus an ignored load while busy
    repeat (22) @(negedge clk);
    chk("digit3_lit", an, 8'hF7);
    wr_en = 1'b1; wr_data = 32'hFFFFFFFF; wr_dp = 8'h00;
    @(negedge clk);
    chk("busy_ready", wr_ready, 0);
    wr_data = 32'hDEADBEEF;
    @(negedge clk); wr_en = 1'b0;
    wait_tick(24, "tick_commit");
    @(negedge clk);
    chk("ready_after_tick", wr_ready, 1);

    push_frame(32'h00000050, 8'h04, 0, 7);
    push_frame(32'h00000050, 8'h04, 0, 5);
    wr_en = 1'b1; wr_data = 32'h00000050; wr_dp = 8'h04;
    @(negedge clk); wr_en = 1'b0;
    wait_tick(46, "tick_frame3");
    wait_tick(48, "tick_period");

    // drop enable during digit 5
    repeat (35) @(negedge clk);
    chk("digit5_lit", an, 8'hDF);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("disable_an", an, 8'hFF);
    chk("disable_seg", seg, 8'hFF);
    repeat (3) @(negedge clk);
    chk("idle_an", an, 8'hFF);

    push_frame(32'h00000050, 8'h04, 0, 0);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an == 8'hFF && n < 20);
    chk("reenable_delay", 16'(n), 16'd4);
    chk("reenable_an", an, 8'hFE);

    // reset with a load pending: it must never reach the pins
    wr_en = 1'b1; wr_data = 32'h87654321; wr_dp = 8'hFF;
    @(negedge clk); wr_en = 1'b0;
    chk("pending_ready", wr_ready, 0);
    rst = 1'b1;
    push_frame(32'h0, 8'h00, 0, 7);
    push_frame(32'h0, 8'h00, 0, 7);
    @(negedge clk);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_ready", wr_ready, 1);
    rst = 1'b0;
    wait_tick(48, "tick_after_rst");
    wait_tick(48, "tick_after_rst2");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
